// File: rtl/sub_seriale_if.sv
// Operand/result bundle for the bit-serial subtractor: the requester drives
// start/A/B and the subtractor returns D/Bout with busy/done status.
interface sub_seriale_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    modport master (output start, A, B, input D, Bout, busy, done);
    modport slave  (input start, A, B, output D, Bout, busy, done);
endinterface

// File: rtl/sub_seriale.sv
// Bit-serial unsigned subtractor: computes (A - B) mod 2^N one bit per cycle,
// LSB first, reporting the final borrow and a one-cycle done pulse.
module sub_seriale #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    sub_seriale_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  d_q, d_d;
    logic          borrow_q, borrow_d;
    logic          bout_q, bout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          diff_bit;
    logic          borrow_next;

    // One full-subtractor slice working on the current LSBs.
    assign diff_bit    = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first, so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                r_d      = {diff_bit, r_q[N-1:1]};
                borrow_d = borrow_next;
                cnt_d    = cnt_q + CW'(1);
                // Last bit: publish the completed result on this same edge.
                if (cnt_q == CW'(N - 1)) begin
                    d_d     = {diff_bit, r_q[N-1:1]};
                    bout_d  = borrow_next;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: doc/sub_seriale.md
SUB_SERIALE -- requirements
Module: sub_seriale

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to compute A - B; sampled on rising clk edges.
REQ-005 The module SHALL have port A, input, N bits: minuend, unsigned.
REQ-006 The module SHALL have port B, input, N bits: subtrahend, unsigned.
REQ-007 The module SHALL have port D, output, N bits: registered difference (A - B) mod 2^N.
REQ-008 The module SHALL have port Bout, output, 1 bit: registered final borrow; 1 iff A < B.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse marking D and Bout as newly valid.

Function
REQ-011 The module SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE); both are decoded from registered state only.
REQ-012 In IDLE, start=1 at a rising edge SHALL capture A and B into internal shift registers, clear the borrow flip-flop and the bit counter, and move the FSM to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-013 start SHALL be ignored in RUN and in DONE; A and B SHALL be sampled only at acceptance, so later input changes cannot affect the result.
REQ-014 Each RUN cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ bin; bnext = (~a0 & b0) | (~(a0 ^ b0) & bin), where a0 and b0 are the current LSBs of the shift registers and bin is the borrow flip-flop.
REQ-015 Each RUN edge SHALL shift both operand registers right by one, shift d into the MSB of an internal result register, and load bnext into the borrow flip-flop.
REQ-016 RUN SHALL last exactly N cycles, counted by a counter of width ceil(log2(N+1)); on the N-th RUN edge the FSM SHALL go to DONE.
REQ-017 On that same edge, D SHALL load the complete N-bit result and Bout SHALL load the final borrow.
REQ-018 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-019 Latency: start accepted at edge t gives done=1 between edges t+N and t+N+1; the minimum spacing between accepted starts is N+2 cycles.
REQ-020 D and Bout SHALL change only on the completion edge (REQ-017) or on reset, and SHALL hold their values through IDLE and the next RUN.
REQ-021 Wrap-around: D SHALL equal (A + 2^N - B) mod 2^N for all inputs, including A=0, B=2^N-1.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, force: state=IDLE, D=0, Bout=0, busy=0, done=0; the shift registers, borrow flip-flop and counter SHALL all be cleared.
REQ-023 rst asserted during RUN SHALL abort the operation; D and Bout SHALL read 0 afterwards, and no done pulse SHALL follow.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-025 N=4, A=9, B=3, start pulse at edge t -> busy high for 4 cycles, done at t+4, D=6, Bout=0.
REQ-026 A=3, B=9 -> D=4'hA, Bout=1; A=0, B=1 -> D=4'hF, Bout=1; A=0, B=0 -> D=0, Bout=0; A=15, B=15 -> D=0, Bout=0.
REQ-027 start held high continuously with A=9, B=3 and inputs changed to A=1, B=2 during RUN -> exactly one done per 6 cycles; the first result is D=6 and is unaffected by the input change.
REQ-028 rst pulsed asynchronously between edges during the 2nd RUN cycle -> outputs go to 0 before the next edge, there is no done, and a subsequent start with A=5, B=7 gives D=4'hE, Bout=1.
REQ-029 Exhaustive sweep of all 256 (A,B) pairs at N=4, compared against a reference model -> D and Bout match on every done, and busy/done never overlap.
REQ-030 At N=8, A=8'h00, B=8'hFF -> done 8 cycles after start, D=8'h01, Bout=1.
